logic_unit: RTL and testbench
=============================

Name: logic_unit

Overview:
- 16-bit bitwise logic unit of the ALU datapath. Selects one of eight bitwise operations on two operands via a 3-bit opcode.
- Registers the result with one cycle of latency.
- Sits beside the arithmetic unit. Its registered result and flags feed the ALU output mux.

Parameters:
- WIDTH, 16, operand and result width in bits. All behaviour below is per-bit and holds for any WIDTH ≥ 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and sel are valid this cycle.
- in0  input  WIDTH  operand A.
- in1  input  WIDTH  operand B.
- sel  input  3  operation select.
- result  output  WIDTH  registered operation result.
- out_valid  output  1  result was captured from a valid input on the previous edge.
- zero  output  1  registered flag, result == 0.
- parity  output  1  registered XOR-reduction of result.

Behaviour:
- Opcode map (bitwise, every bit position independent):
  - 000 AND: in0 & in1
  - 001 OR: in0 | in1
  - 010 XOR: in0 ^ in1
  - 011 NAND: ~(in0 & in1)
  - 100 NOR: ~(in0 | in1)
  - 101 XNOR: ~(in0 ^ in1)
  - 110 NOT A: ~in0 (in1 ignored)
  - 111 ANDN: in0 & ~in1
- No carries, no shifts, no cross-bit interaction. Result width equals WIDTH; there is no truncation or extension.
- rst_n low, at any time and independent of clk:
  - result = 0, out_valid = 0, zero = 0, parity = 0, immediately.
  - Reset mid-operation discards any in-flight value.
  - After rst_n deasserts, the first rising edge with in_valid = 1 produces valid output.
- Rising clk with in_valid = 1:
  - result <= op(sel, in0, in1)
  - zero <= (op result == 0)
  - parity <= ^op result
  - out_valid <= 1
- Rising clk with in_valid = 0:
  - result, zero and parity hold their previous values.
  - out_valid <= 0.
- Latency is exactly 1 cycle. Back-to-back valid inputs give one result per cycle with no stalls; there is no backpressure.
- Changing sel or operands between edges has no effect on outputs until the next capturing edge.
- X/unknown on sel while in_valid = 1 is illegal stimulus. The design carries no special handling for it. A full case with no latch is required.

Test Plan:
- Reset:
  - Drive rst_n = 0 mid-cycle with prior result 0xFFFF. Expect result = 0x0000, out_valid = 0, zero = 0, parity = 0 immediately, without waiting for a clock edge.
- LSB truth table:
  - For each sel 000–111, apply (in0, in1) = (0,0), (0,1), (1,0), (1,1) with in_valid = 1.
  - One cycle later, bit 0 follows the opcode table.
  - Upper bits are 0 for AND/OR/XOR/ANDN and 1 for NAND/NOR/XNOR/NOT. Example: sel = 100, in0 = 0, in1 = 0 gives 0xFFFF.
- Full-width patterns:
  - in0 = 0xA5A5, in1 = 0x0FF0.
  - Expect AND 0x05A0, OR 0xAFF5, XOR 0xAA55, NAND 0xFA5F, NOR 0x500A, XNOR 0x55AA, NOT 0x5A5A, ANDN 0xA005.
- Flags:
  - sel = 010, in0 = in1 = 0x1234 gives result 0, zero = 1, parity = 0.
  - sel = 001, in0 = 0x0001, in1 = 0 gives zero = 0, parity = 1.
- Valid/hold:
  - A valid AND op, then in_valid = 0 with different operands for 3 cycles.
  - Expect result, zero and parity unchanged and out_valid = 1 then 0, 0, 0.
  - Then back-to-back valid ops each produce their result on the following edge.
- Reset during stream:
  - Assert rst_n low between two valid ops. Outputs clear immediately.
  - The first valid op after release appears one cycle later with out_valid = 1.

Source files
------------

// File: rtl/logic_unit_if.sv
// logic_unit_if: operand/opcode request and registered result/flags of the logic unit
interface logic_unit_if #(parameter int WIDTH = 16);
   logic             in_valid;
   logic [WIDTH-1:0] in0;
   logic [WIDTH-1:0] in1;
   logic [2:0]       sel;
   logic [WIDTH-1:0] result;
   logic             out_valid;
   logic             zero;
   logic             parity;
   modport master (output in_valid, in0, in1, sel, input result, out_valid, zero, parity);
   modport slave  (input in_valid, in0, in1, sel, output result, out_valid, zero, parity);
endinterface

// File: rtl/logic_unit.sv
// logic_unit: 16-bit bitwise logic unit with registered result, zero and parity flags
module logic_unit #(parameter int WIDTH = 16) (
   input logic         clk,
   input logic         rst_n,
   logic_unit_if.slave bus
);
   logic [WIDTH-1:0] op;
   always_comb begin
      op = '0;
      case (bus.sel)
         3'b000:  op = bus.in0 & bus.in1;
         3'b001:  op = bus.in0 | bus.in1;
         3'b010:  op = bus.in0 ^ bus.in1;
         3'b011:  op = ~(bus.in0 & bus.in1);
         3'b100:  op = ~(bus.in0 | bus.in1);
         3'b101:  op = ~(bus.in0 ^ bus.in1);
         3'b110:  op = ~bus.in0;
         default: op = bus.in0 & ~bus.in1;
      endcase
   end
   // result and flags hold while idle; only out_valid tracks every edge
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bus.result    <= '0;
         bus.out_valid <= 1'b0;
         bus.zero      <= 1'b0;
         bus.parity    <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.result <= op;
            bus.zero   <= op == '0;
            bus.parity <= ^op;
         end
      end
endmodule

// File: tb/tb_logic_unit.sv
// tb_logic_unit: directed self-checking bench for logic_unit
module tb_logic_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic_unit_if #(.WIDTH(16)) bus ();
   logic_unit #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   // bit-0 truth tables indexed by {a,b}, and which opcodes fill upper bits with ones
   logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0011, 4'b0100};
   logic [7:0] upper_ones = 8'b0111_1000;
   logic [15:0] pat_exp [8] = '{16'h05A0, 16'hAFF5, 16'hAA55, 16'hFA5F, 16'h500A, 16'h55AA, 16'h5A5A, 16'hA005};

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [15:0] r, input logic z, input logic p, input logic v);
      check({tag, ".result"}, bus.result, r);
      check({tag, ".zero"}, {15'd0, bus.zero}, {15'd0, z});
      check({tag, ".parity"}, {15'd0, bus.parity}, {15'd0, p});
      check({tag, ".out_valid"}, {15'd0, bus.out_valid}, {15'd0, v});
   endtask

   task automatic op(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.sel = s;
      bus.in0 = a;
      bus.in1 = b;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.sel = s;
      bus.in0 = a;
      bus.in1 = b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] e;
      bus.in_valid = 1'b0;
      bus.sel = 3'b000;
      bus.in0 = '0;
      bus.in1 = '0;
      #1;
      check_out("por", 16'h0000, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      // asynchronous clear from a 0xFFFF result, mid-cycle
      op(3'b100, 16'h0000, 16'h0000);
      check_out("nor_ffff", 16'hFFFF, 1'b0, 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_out("async_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int s = 0; s < 8; s++)
         for (int ab = 0; ab < 4; ab++) begin
            op(3'(s), {15'd0, ab[1]}, {15'd0, ab[0]});
            e = {{15{upper_ones[s]}}, tt[s][ab]};
            check($sformatf("tt_sel%0d_ab%0d", s, ab), bus.result, e);
            check($sformatf("tt_v_sel%0d_ab%0d", s, ab), {15'd0, bus.out_valid}, 16'd1);
         end
      for (int s = 0; s < 8; s++) begin
         op(3'(s), 16'hA5A5, 16'h0FF0);
         check_out($sformatf("pat_sel%0d", s), pat_exp[s], 1'b0, 1'b0, 1'b1);
      end
      op(3'b010, 16'h1234, 16'h1234);
      check_out("flag_zero", 16'h0000, 1'b1, 1'b0, 1'b1);
      op(3'b001, 16'h0001, 16'h0000);
      check_out("flag_par", 16'h0001, 1'b0, 1'b1, 1'b1);
      op(3'b000, 16'h0F01, 16'h0F03);
      check_out("hold_op", 16'h0F01, 1'b0, 1'b1, 1'b1);
      idle(3'b100, 16'h0000, 16'h0000);
      check_out("hold1", 16'h0F01, 1'b0, 1'b1, 1'b0);
      idle(3'b010, 16'h5555, 16'h5555);
      check_out("hold2", 16'h0F01, 1'b0, 1'b1, 1'b0);
      idle(3'b110, 16'h1234, 16'hFFFF);
      check_out("hold3", 16'h0F01, 1'b0, 1'b1, 1'b0);
      op(3'b001, 16'h00F0, 16'h0F00);
      check_out("b2b1", 16'h0FF0, 1'b0, 1'b0, 1'b1);
      op(3'b111, 16'hFFFF, 16'hFFFE);
      check_out("b2b2", 16'h0001, 1'b0, 1'b1, 1'b1);
      op(3'b101, 16'hFFFF, 16'h0000);
      check_out("b2b3", 16'h0000, 1'b1, 1'b0, 1'b1);
      op(3'b110, 16'h0000, 16'h1234);
      check_out("pre_rst", 16'hFFFF, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_out("stream_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_out("rst_held", 16'h0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      op(3'b000, 16'h8001, 16'h8003);
      check_out("post_rst", 16'h8001, 1'b0, 1'b0, 1'b1);
      idle(3'b000, 16'h0000, 16'h0000);
      check_out("post_idle", 16'h8001, 1'b0, 1'b0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
